// File: rtl/micro_ctrl_seq.sv
// micro_ctrl_seq -- four-state micro-sequencer for a tiny accumulator-style ISA.
//
// Each instruction moves through FETCH -> DECODE -> EXECUTE1 -> EXECUTE2 and
// then returns to FETCH. A HALT instruction parks the sequencer in HALT until
// the next reset.
//
// Instruction format: op = ir[7:6], rd = ir[5:4], imm = ir[3:0] (zero-extended)
//   00 LDI  rd <- imm
//   01 ADD  rd <- rd + imm   (modulo 2^DATA_WIDTH)
//   10 SUB  rd <- rd - imm   (modulo 2^DATA_WIDTH)
//   11 HALT
//
// Ports
//   sys_clk      in   single clock, rising edge
//   sys_reset    in   synchronous active-low reset
//   imem_req     out  instruction fetch request (FETCH only)
//   imem_addr    out  fetch address (program counter)
//   imem_ack     in   fetch complete, imem_data valid this cycle
//   imem_data    in   fetched instruction
//   cpu_state    out  current sequencer state (shared encoding below)
//   reg_file_en  out  register file access enable
//   reg_file_rw  out  `REG_FILE_READ / `REG_FILE_WRITE
//   reg_sel      out  register address
//   reg_wr_data  out  register write data (0 unless writing)
//   reg_rd_data  in   register read data, valid the cycle after a read
//   halted       out  high while in HALT

`ifndef CPU_STATES
`define CPU_STATES 5
`endif
`ifndef CPU_FETCH
`define CPU_FETCH 0
`endif
`ifndef CPU_DECODE
`define CPU_DECODE 1
`endif
`ifndef CPU_EXECUTE1
`define CPU_EXECUTE1 2
`endif
`ifndef CPU_EXECUTE2
`define CPU_EXECUTE2 3
`endif
`ifndef CPU_HALT
`define CPU_HALT 4
`endif
`ifndef REG_FILE_READ
`define REG_FILE_READ 1'b0
`endif
`ifndef REG_FILE_WRITE
`define REG_FILE_WRITE 1'b1
`endif

module micro_ctrl_seq #(
  parameter int DATA_WIDTH     = 8,
  parameter int REG_SPEC_WIDTH = 2,
  parameter int ADDR_WIDTH     = 8
) (
  input  logic                          sys_clk,
  input  logic                          sys_reset,
  output logic                          imem_req,
  output logic [ADDR_WIDTH-1:0]         imem_addr,
  input  logic                          imem_ack,
  input  logic [DATA_WIDTH-1:0]         imem_data,
  output logic [$clog2(`CPU_STATES)-1:0] cpu_state,
  output logic                          reg_file_en,
  output logic                          reg_file_rw,
  output logic [REG_SPEC_WIDTH-1:0]     reg_sel,
  output logic [DATA_WIDTH-1:0]         reg_wr_data,
  input  logic [DATA_WIDTH-1:0]         reg_rd_data,
  output logic                          halted
);

  localparam int SW = $clog2(`CPU_STATES);

  localparam logic [SW-1:0] S_FETCH    = SW'(`CPU_FETCH);
  localparam logic [SW-1:0] S_DECODE   = SW'(`CPU_DECODE);
  localparam logic [SW-1:0] S_EXECUTE1 = SW'(`CPU_EXECUTE1);
  localparam logic [SW-1:0] S_EXECUTE2 = SW'(`CPU_EXECUTE2);
  localparam logic [SW-1:0] S_HALT     = SW'(`CPU_HALT);

  localparam logic [1:0] OP_LDI  = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;
  localparam logic [1:0] OP_HALT = 2'b11;

  logic [SW-1:0]             state_r;
  logic [SW-1:0]             next_state_s;
  logic [ADDR_WIDTH-1:0]     pc_r;
  logic [DATA_WIDTH-1:0]     ir_r;

  logic [1:0]                op_s;
  logic [REG_SPEC_WIDTH-1:0] rd_s;
  logic [DATA_WIDTH-1:0]     imm_s;

  assign op_s  = ir_r[7:6];
  assign rd_s  = REG_SPEC_WIDTH'(ir_r[5:4]);
  assign imm_s = {{(DATA_WIDTH-4){1'b0}}, ir_r[3:0]};

  // State, program counter and instruction register
  always_ff @(posedge sys_clk) begin
    if (!sys_reset) begin
      state_r <= S_FETCH;
      pc_r    <= '0;
      ir_r    <= '0;
    end else begin
      state_r <= next_state_s;
      // Only a fetch that is acknowledged while in FETCH loads a new instruction
      if ((state_r == S_FETCH) && imem_ack) begin
        ir_r <= imem_data;
        pc_r <= pc_r + ADDR_WIDTH'(1);
      end else begin
        ir_r <= ir_r;
        pc_r <= pc_r;
      end
    end
  end

  // Next-state decode
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_FETCH: begin
        if (imem_ack) begin
          next_state_s = S_DECODE;
        end else begin
          next_state_s = S_FETCH;
        end
      end
      S_DECODE: begin
        if (op_s == OP_HALT) begin
          next_state_s = S_HALT;
        end else begin
          next_state_s = S_EXECUTE1;
        end
      end
      S_EXECUTE1: next_state_s = S_EXECUTE2;
      S_EXECUTE2: next_state_s = S_FETCH;
      S_HALT:     next_state_s = S_HALT;
      default:    next_state_s = S_FETCH;
    endcase
  end

  // Output decode; reset overrides enables combinationally so an in-flight
  // register write is cancelled in the same cycle reset is asserted
  always_comb begin
    imem_req    = 1'b0;
    reg_file_en = 1'b0;
    reg_file_rw = `REG_FILE_READ;
    reg_sel     = '0;
    reg_wr_data = '0;
    case (state_r)
      S_FETCH: imem_req = 1'b1;
      S_DECODE: reg_file_en = 1'b0;
      S_EXECUTE1: begin
        reg_file_en = 1'b1;
        reg_sel     = rd_s;
        if (op_s == OP_LDI) begin
          reg_file_rw = `REG_FILE_WRITE;
          reg_wr_data = imm_s;
        end else begin
          reg_file_rw = `REG_FILE_READ;
        end
      end
      S_EXECUTE2: begin
        // Read-modify-write completes here using last cycle's read data
        if (op_s == OP_ADD) begin
          reg_file_en = 1'b1;
          reg_file_rw = `REG_FILE_WRITE;
          reg_sel     = rd_s;
          reg_wr_data = reg_rd_data + imm_s;
        end else if (op_s == OP_SUB) begin
          reg_file_en = 1'b1;
          reg_file_rw = `REG_FILE_WRITE;
          reg_sel     = rd_s;
          reg_wr_data = reg_rd_data - imm_s;
        end else begin
          reg_file_en = 1'b0;
        end
      end
      S_HALT: reg_file_en = 1'b0;
      default: reg_file_en = 1'b0;
    endcase
    if (!sys_reset) begin
      imem_req    = 1'b0;
      reg_file_en = 1'b0;
      reg_file_rw = `REG_FILE_READ;
      reg_wr_data = '0;
    end else begin
      imem_req    = imem_req;
      reg_file_en = reg_file_en;
    end
  end

  assign imem_addr = pc_r;
  assign cpu_state = state_r;
  assign halted    = (state_r == S_HALT);

endmodule

// File: tb/tb_micro_ctrl_seq.sv
// Directed table-driven bench for micro_ctrl_seq plus hand-written sequences
// for PC wrap into HALT and reset asserted mid-instruction.

module tb_micro_ctrl_seq;

  localparam logic [2:0] ST_F  = 3'd0;
  localparam logic [2:0] ST_D  = 3'd1;
  localparam logic [2:0] ST_E1 = 3'd2;
  localparam logic [2:0] ST_E2 = 3'd3;
  localparam logic [2:0] ST_H  = 3'd4;

  logic       sys_clk;
  logic       sys_reset;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       imem_ack;
  logic [7:0] imem_data;
  logic [2:0] cpu_state;
  logic       reg_file_en;
  logic       reg_file_rw;
  logic [1:0] reg_sel;
  logic [7:0] reg_wr_data;
  logic [7:0] reg_rd_data;
  logic       halted;

  int n_checks = 0;
  int n_fail   = 0;

  micro_ctrl_seq dut (
    .sys_clk     (sys_clk),
    .sys_reset   (sys_reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_data   (imem_data),
    .cpu_state   (cpu_state),
    .reg_file_en (reg_file_en),
    .reg_file_rw (reg_file_rw),
    .reg_sel     (reg_sel),
    .reg_wr_data (reg_wr_data),
    .reg_rd_data (reg_rd_data),
    .halted      (halted)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic       rst;
    logic       ack;
    logic [7:0] data;
    logic [7:0] rdd;
    logic       full;
    logic [2:0] st;
    logic       req;
    logic [7:0] addr;
    logic       en;
    logic       rw;
    logic [1:0] sel;
    logic [7:0] wd;
    logic       halt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic ack, input logic [7:0] data,
                     input logic [7:0] rdd, input logic full, input logic [2:0] st,
                     input logic req, input logic [7:0] addr, input logic en,
                     input logic rw, input logic [1:0] sel, input logic [7:0] wd,
                     input logic halt);
    vec_t v;
    v.rst = rst; v.ack = ack; v.data = data; v.rdd = rdd; v.full = full;
    v.st = st; v.req = req; v.addr = addr; v.en = en; v.rw = rw;
    v.sel = sel; v.wd = wd; v.halt = halt;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive inputs just after the falling edge, then let combinational outputs settle
  task automatic step(input logic rst, input logic ack, input logic [7:0] data,
                      input logic [7:0] rdd);
    @(negedge sys_clk);
    sys_reset   = rst;
    imem_ack    = ack;
    imem_data   = data;
    reg_rd_data = rdd;
    #1;
  endtask

  initial begin
    sys_reset   = 1'b0;
    imem_ack    = 1'b0;
    imem_data   = 8'h00;
    reg_rd_data = 8'h00;

    //   rst  ack  data   rdd   full st    req  addr   en   rw   sel   wd     halt
    // reset for two edges
    add(1'b0,1'b0,8'h00,8'h00,1'b0,ST_F, 1'b0,8'h00,1'b0,1'b0,2'd0,8'h00,1'b0);
    add(1'b0,1'b0,8'h00,8'h00,1'b1,ST_F, 1'b0,8'h00,1'b0,1'b0,2'd0,8'h00,1'b0);
    // LDI r0,0xA with zero-wait ack
    add(1'b1,1'b1,8'h0A,8'h00,1'b1,ST_F, 1'b1,8'h00,1'b0,1'b0,2'd0,8'h00,1'b0);
    add(1'b1,1'b0,8'h00,8'h00,1'b1,ST_D, 1'b0,8'h01,1'b0,1'b0,2'd0,8'h00,1'b0);
    add(1'b1,1'b0,8'h00,8'h00,1'b1,ST_E1,1'b0,8'h01,1'b1,1'b1,2'd0,8'h0A,1'b0);
    add(1'b1,1'b0,8'h00,8'h00,1'b1,ST_E2,1'b0,8'h01,1'b0,1'b0,2'd0,8'h00,1'b0);
    // ADD r1,3 with read data 0xFE -> wraps to 0x01
    add(1'b1,1'b1,8'h53,8'h00,1'b1,ST_F, 1'b1,8'h01,1'b0,1'b0,2'd0,8'h00,1'b0);
    add(1'b1,1'b0,8'h00,8'h00,1'b1,ST_D, 1'b0,8'h02,1'b0,1'b0,2'd0,8'h00,1'b0);
    add(1'b1,1'b0,8'h00,8'h00,1'b1,ST_E1,1'b0,8'h02,1'b1,1'b0,2'd1,8'h00,1'b0);
    add(1'b1,1'b0,8'h00,8'hFE,1'b1,ST_E2,1'b0,8'h02,1'b1,1'b1,2'd1,8'h01,1'b0);
    // SUB r2,5 with ack delayed 3 cycles; stray acks in DECODE/EXECUTE1 ignored
    add(1'b1,1'b0,8'h00,8'h00,1'b1,ST_F, 1'b1,8'h02,1'b0,1'b0,2'd0,8'h00,1'b0);
    add(1'b1,1'b0,8'h00,8'h00,1'b1,ST_F, 1'b1,8'h02,1'b0,1'b0,2'd0,8'h00,1'b0);
    add(1'b1,1'b0,8'h00,8'h00,1'b1,ST_F, 1'b1,8'h02,1'b0,1'b0,2'd0,8'h00,1'b0);
    add(1'b1,1'b1,8'hA5,8'h00,1'b1,ST_F, 1'b1,8'h02,1'b0,1'b0,2'd0,8'h00,1'b0);
    add(1'b1,1'b1,8'hC0,8'h00,1'b1,ST_D, 1'b0,8'h03,1'b0,1'b0,2'd0,8'h00,1'b0);
    add(1'b1,1'b1,8'hC0,8'h00,1'b1,ST_E1,1'b0,8'h03,1'b1,1'b0,2'd2,8'h00,1'b0);
    add(1'b1,1'b0,8'h00,8'h02,1'b1,ST_E2,1'b0,8'h03,1'b1,1'b1,2'd2,8'hFD,1'b0);
    add(1'b1,1'b0,8'h00,8'h00,1'b1,ST_F, 1'b1,8'h03,1'b0,1'b0,2'd0,8'h00,1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].ack, vecs[i].data, vecs[i].rdd);
      chk($sformatf("v%0d.req", i), 32'(imem_req), 32'(vecs[i].req));
      chk($sformatf("v%0d.en", i), 32'(reg_file_en), 32'(vecs[i].en));
      if (vecs[i].full) begin
        chk($sformatf("v%0d.state", i), 32'(cpu_state), 32'(vecs[i].st));
        chk($sformatf("v%0d.addr", i), 32'(imem_addr), 32'(vecs[i].addr));
        chk($sformatf("v%0d.wd", i), 32'(reg_wr_data), 32'(vecs[i].wd));
        chk($sformatf("v%0d.halt", i), 32'(halted), 32'(vecs[i].halt));
        if (vecs[i].en) begin
          chk($sformatf("v%0d.rw", i), 32'(reg_file_rw), 32'(vecs[i].rw));
          chk($sformatf("v%0d.sel", i), 32'(reg_sel), 32'(vecs[i].sel));
        end
      end
    end

    // Step through LDI r3,0 instructions until the PC reaches 0xFF
    for (int a = 3; a < 255; a++) begin
      step(1'b1, 1'b1, 8'h30, 8'h00);
      chk("walk.addr", 32'(imem_addr), 32'(a));
      chk("walk.state", 32'(cpu_state), 32'(ST_F));
      step(1'b1, 1'b0, 8'h00, 8'h00);
      step(1'b1, 1'b0, 8'h00, 8'h00);
      step(1'b1, 1'b0, 8'h00, 8'h00);
    end

    // HALT fetched from 0xFF; PC wraps to 0x00
    step(1'b1, 1'b1, 8'hC0, 8'h00);
    chk("hlt.f.addr", 32'(imem_addr), 32'h0000_00FF);
    chk("hlt.f.req", 32'(imem_req), 32'd1);
    step(1'b1, 1'b0, 8'h00, 8'h00);
    chk("hlt.d.state", 32'(cpu_state), 32'(ST_D));
    chk("hlt.d.addr", 32'(imem_addr), 32'h0000_0000);
    for (int k = 0; k < 6; k++) begin
      step(1'b1, k[0] ? 1'b0 : 1'b1, 8'h0A, 8'h00);
      chk("hlt.state", 32'(cpu_state), 32'(ST_H));
      chk("hlt.halted", 32'(halted), 32'd1);
      chk("hlt.req", 32'(imem_req), 32'd0);
      chk("hlt.en", 32'(reg_file_en), 32'd0);
      chk("hlt.addr", 32'(imem_addr), 32'h0000_0000);
    end

    // Reset out of HALT, run ADD r1,3 and assert reset during EXECUTE1
    step(1'b0, 1'b0, 8'h00, 8'h00);
    chk("rm.rst.req", 32'(imem_req), 32'd0);
    step(1'b1, 1'b1, 8'h53, 8'h00);
    chk("rm.f.state", 32'(cpu_state), 32'(ST_F));
    chk("rm.f.halted", 32'(halted), 32'd0);
    chk("rm.f.req", 32'(imem_req), 32'd1);
    step(1'b1, 1'b0, 8'h00, 8'h00);
    chk("rm.d.addr", 32'(imem_addr), 32'h0000_0001);
    step(1'b1, 1'b0, 8'h00, 8'h00);
    chk("rm.e1.en", 32'(reg_file_en), 32'd1);
    chk("rm.e1.state", 32'(cpu_state), 32'(ST_E1));
    step(1'b0, 1'b0, 8'h00, 8'h00);
    chk("rm.rst.en", 32'(reg_file_en), 32'd0);
    chk("rm.rst.req2", 32'(imem_req), 32'd0);
    chk("rm.rst.wd", 32'(reg_wr_data), 32'd0);
    step(1'b1, 1'b0, 8'h00, 8'hFE);
    chk("rm.post.state", 32'(cpu_state), 32'(ST_F));
    chk("rm.post.addr", 32'(imem_addr), 32'h0000_0000);
    chk("rm.post.req", 32'(imem_req), 32'd1);
    chk("rm.post.en", 32'(reg_file_en), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/micro_ctrl_seq.md
MICRO_CTRL_SEQ -- requirements
Module: micro_ctrl_seq

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, register/instruction data width.
REQ-002 SHALL have parameter REG_SPEC_WIDTH, default 2, register select width (4 registers).
REQ-003 SHALL have parameter ADDR_WIDTH, default 8, instruction memory address width.
REQ-004 SHALL have port sys_clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port sys_reset  input  1  synchronous, active-low reset (asserted when 0, sampled on sys_clk rising edge).
REQ-006 SHALL have port imem_req  output  1  instruction fetch request.
REQ-007 SHALL have port imem_addr  output  ADDR_WIDTH  fetch address (program counter).
REQ-008 SHALL have port imem_ack  input  1  fetch complete; imem_data valid this cycle.
REQ-009 SHALL have port imem_data  input  DATA_WIDTH  fetched instruction.
REQ-010 SHALL have port cpu_state  output  $clog2(`CPU_STATES)  current state, shared state encoding.
REQ-011 SHALL have port reg_file_en  output  1  register file access enable.
REQ-012 SHALL have port reg_file_rw  output  1  `REG_FILE_READ / `REG_FILE_WRITE.
REQ-013 SHALL have port reg_sel  output  REG_SPEC_WIDTH  register address.
REQ-014 SHALL have port reg_wr_data  output  DATA_WIDTH  register write data.
REQ-015 SHALL have port reg_rd_data  input  DATA_WIDTH  register read data, valid the cycle after a read request.
REQ-016 SHALL have port halted  output  1  high while in HALT.

Function
REQ-017 SHALL decode instruction ir as: op=ir[7:6], rd=ir[5:4], imm=ir[3:0] zero-extended to DATA_WIDTH.
REQ-018 SHALL implement ops: 00 LDI rd<-imm; 01 ADD rd<-rd+imm; 10 SUB rd<-rd-imm; 11 HALT; arithmetic modulo 2^DATA_WIDTH, no flags.
REQ-019 SHALL sequence states FETCH -> DECODE -> EXECUTE1 -> EXECUTE2 -> FETCH, plus HALT; pc, ir, state registered.
REQ-020 FETCH: imem_req=1, imem_addr=pc held stable; stay in FETCH until imem_ack=1 sampled; on ack latch ir<-imem_data, pc<-pc+1 (255 wraps to 0), go DECODE.
REQ-021 imem_ack in the same cycle imem_req first rises SHALL be accepted (zero-wait fetch, 4 cycles per instruction).
REQ-022 imem_ack outside FETCH SHALL be ignored; imem_req=0 in all states except FETCH.
REQ-023 DECODE: reg_file_en=0; go HALT if op=11, else EXECUTE1.
REQ-024 EXECUTE1: LDI -> en=1, rw=WRITE, reg_sel=rd, reg_wr_data=imm; ADD/SUB -> en=1, rw=READ, reg_sel=rd.
REQ-025 EXECUTE2: ADD/SUB -> en=1, rw=WRITE, reg_sel=rd, reg_wr_data=reg_rd_data+/-imm (combinational from reg_rd_data); LDI -> en=0; then FETCH.
REQ-026 HALT: en=0, imem_req=0, halted=1; remain until reset.
REQ-027 reg_file_en SHALL be 0 in FETCH, DECODE, HALT; reg_wr_data SHALL be 0 when en=0 or rw=READ.

Reset
REQ-028 While sys_reset=0 at a rising edge: state<-FETCH, pc<-0, ir<-0.
REQ-029 reg_file_en and imem_req SHALL be forced 0 combinationally while sys_reset=0, including reset asserted mid-EXECUTE1/EXECUTE2.
REQ-030 After reset release: cpu_state=FETCH, imem_addr=0, halted=0, reg_file_en=0; first fetch starts that cycle.

Verification
REQ-031 Reset: sys_reset=0 for 2 edges -> cpu_state=FETCH, imem_addr=0x00, imem_req=0 during reset then 1, halted=0.
REQ-032 LDI: imem_data=0x0A, ack immediate -> DECODE, EXECUTE1 en=1 rw=WRITE sel=0 wr_data=0x0A, EXECUTE2 en=0, FETCH with imem_addr=0x01.
REQ-033 ADD wrap: 0x53, reg_rd_data=0xFE in EXECUTE2 -> EXECUTE1 READ sel=1; EXECUTE2 WRITE sel=1 wr_data=0x01.
REQ-034 SUB wrap + wait: 0xA5, ack delayed 3 cycles -> FETCH held 4 cycles, addr stable; reg_rd_data=0x02 -> wr_data=0xFD sel=2.
REQ-035 HALT/PC wrap: pc=0xFF fetching 0xC0 -> pc=0x00, HALT, halted=1, imem_req=0 indefinitely; imem_ack pulses ignored.
REQ-036 Reset mid-op: sys_reset=0 during EXECUTE1 of ADD -> reg_file_en=0 immediately, no write; next edge FETCH, pc=0x00.
